// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared RV32I pipeline types and constants.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] instr_t;
  typedef logic [XLEN-1:0] addr_t;

  // addi x0,x0,0 : the canonical bubble inserted on reset and on redirect
  localparam instr_t NOP_INSTR = 32'h0000_0013;
  localparam addr_t  RESET_PC  = 32'h0000_0000;
  localparam addr_t  PC_INCR   = 32'd4;

endpackage
`default_nettype wire

// File: rtl/fetch_decode_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_decode_if
// Brief    : Fetch-to-decode pipeline bundle (instruction and its PC).
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_decode_if;
  import riscv_pkg::*;

  addr_t  pc;
  instr_t instruction;

  modport fetch (
    output pc,
    output instruction
  );

  modport decode (
    input pc,
    input instruction
  );

endinterface
`default_nettype wire

// File: rtl/memory_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : memory_fetch_if
// Brief    : Fetch-stage <-> instruction-memory / control handshake bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface memory_fetch_if;
  import riscv_pkg::*;

  logic   read_enable;
  logic   take_branch;
  addr_t  condpc;
  instr_t write_instruction;
  addr_t  imem_addr;
  addr_t  npc;

  modport fetch (
    input  read_enable,
    input  take_branch,
    input  condpc,
    input  write_instruction,
    output imem_addr,
    output npc
  );

  modport mem (
    output read_enable,
    output take_branch,
    output condpc,
    output write_instruction,
    input  imem_addr,
    input  npc
  );

endinterface
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen
// Brief    : Program counter register with redirect/increment next-PC mux.
// Revision : 1.0 - initial release
// ============================================================================
module pc_gen
  import riscv_pkg::*;
#(
  parameter addr_t RESET_PC = riscv_pkg::RESET_PC
) (
  input  logic  clk,
  input  logic  reset,        // asynchronous, active-low
  input  logic  read_enable,
  input  logic  take_branch,
  input  addr_t condpc,
  output addr_t pc,
  output addr_t npc
);

  addr_t r_pc;
  addr_t w_npc;

  // Sequential successor; 32-bit add wraps naturally past 0xFFFF_FFFC
  assign w_npc = r_pc + PC_INCR;

  // PC register: redirect beats stall, condpc low bits dropped for alignment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= RESET_PC;
    end else if (take_branch) begin
      r_pc <= {condpc[31:2], 2'b00};
    end else if (read_enable) begin
      r_pc <= w_npc;
    end
  end

  assign pc  = r_pc;
  assign npc = w_npc;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Brief    : RV32I IF stage - owns the PC, latches fetched word into IR and
//            hands IR plus its address to decode.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter addr_t  RESET_PC  = riscv_pkg::RESET_PC,
  parameter instr_t NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic         clk,
  input  logic         reset,     // asynchronous, active-low
  output instr_t       IR,
  memory_fetch_if.fetch fetch_if,
  fetch_decode_if.fetch dec_if
);

  addr_t  w_pc;
  addr_t  w_npc;
  instr_t r_ir;
  addr_t  r_dec_pc;

  pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk         (clk),
    .reset       (reset),
    .read_enable (fetch_if.read_enable),
    .take_branch (fetch_if.take_branch),
    .condpc      (fetch_if.condpc),
    .pc          (w_pc),
    .npc         (w_npc)
  );

  // IF/ID register: bubble on redirect, capture on enable, hold on stall
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ir     <= NOP_INSTR;
      r_dec_pc <= RESET_PC;
    end else if (fetch_if.take_branch) begin
      r_ir     <= NOP_INSTR;
      r_dec_pc <= w_pc;
    end else if (fetch_if.read_enable) begin
      r_ir     <= fetch_if.write_instruction;
      r_dec_pc <= w_pc;
    end
  end

  assign fetch_if.imem_addr = w_pc;
  assign fetch_if.npc       = w_npc;
  assign IR                 = r_ir;
  assign dec_if.instruction = r_ir;
  assign dec_if.pc          = r_dec_pc;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch
// Brief    : Self-checking bench for instruction_fetch: directed scenarios
//            followed by randomized traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

  localparam logic [31:0] C_NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic [31:0] ir;
  int          checks;
  int          errors;

  // Reference state: architectural view of the stage
  logic [31:0] m_pc;
  logic [31:0] m_ir;
  logic [31:0] m_dpc;

  memory_fetch_if mf ();
  fetch_decode_if dfi ();

  instruction_fetch dut (
    .clk      (clk),
    .reset    (reset),
    .IR       (ir),
    .fetch_if (mf),
    .dec_if   (dfi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc  = 32'h0;
    m_ir  = C_NOP;
    m_dpc = 32'h0;
  endtask

  // Compare every observable output against the reference
  task automatic chk_all(input string tag);
    chk({tag, ".pc"},   mf.imem_addr,      m_pc);
    chk({tag, ".npc"},  mf.npc,            m_pc + 32'd4);
    chk({tag, ".ir"},   ir,                m_ir);
    chk({tag, ".inst"}, dfi.instruction,   m_ir);
    chk({tag, ".dpc"},  dfi.pc,            m_dpc);
  endtask

  // One rising edge: update the reference from the inputs that were present
  task automatic step(input string tag);
    @(posedge clk);
    if (mf.take_branch) begin
      m_dpc = m_pc;
      m_ir  = C_NOP;
      m_pc  = mf.condpc & 32'hFFFF_FFFC;
    end else if (mf.read_enable) begin
      m_dpc = m_pc;
      m_ir  = mf.write_instruction;
      m_pc  = m_pc + 32'd4;
    end
    #1;
    chk_all(tag);
  endtask

  task automatic drive(input logic re, input logic tb, input logic [31:0] cpc,
                       input logic [31:0] wi);
    mf.read_enable       = re;
    mf.take_branch       = tb;
    mf.condpc            = cpc;
    mf.write_instruction = wi;
  endtask

  // Asynchronous reset pulse between edges, checked before any clock edge
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk_all(tag);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    model_reset();
    drive(1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0);

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    chk("reset.ir_const", ir, 32'h13);

    // Sequential fetch
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 1'b0, 32'h1234_5677, 32'hF);
    step("seq0");
    step("seq1");
    step("seq2");
    chk("seq.pc_c",  mf.imem_addr, 32'hC);
    chk("seq.npc_c", mf.npc,       32'h10);
    chk("seq.dpc_c", dfi.pc,       32'h8);
    chk("seq.ir_c",  ir,           32'hF);

    // Stall two edges, then resume
    drive(1'b0, 1'b0, 32'h0000_0200, 32'hAAAA_5555);
    step("stall0");
    step("stall1");
    chk("stall.pc_c", mf.imem_addr, 32'hC);
    drive(1'b1, 1'b0, 32'h0, 32'h0000_0093);
    step("resume");
    chk("resume.pc_c", mf.imem_addr, 32'h10);

    // Redirect to 0x100, then enabled fetch from the target
    drive(1'b1, 1'b1, 32'h100, 32'h1111_1111);
    step("br100");
    chk("br100.pc_c",  mf.imem_addr, 32'h100);
    chk("br100.dpc_c", dfi.pc,       32'h10);
    chk("br100.ir_c",  ir,           32'h13);
    drive(1'b1, 1'b0, 32'h0, 32'h2222_2222);
    step("after100");
    chk("after100.dpc_c", dfi.pc, 32'h100);

    // Unaligned target is word-aligned
    drive(1'b1, 1'b1, 32'hA, 32'h3333_3333);
    step("brA");
    chk("brA.pc_c", mf.imem_addr, 32'h8);

    // Redirect while stalled
    drive(1'b0, 1'b1, 32'h40, 32'h4444_4444);
    step("brstall");
    chk("brstall.pc_c", mf.imem_addr, 32'h40);
    chk("brstall.ir_c", ir,           32'h13);

    // Wrap past the top of the address space
    drive(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0);
    step("wrapbr");
    chk("wrap.npc_c", mf.npc, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 32'h5555_0013);
    step("wrap");
    chk("wrap.pc_c", mf.imem_addr, 32'h0);

    // Mid-run asynchronous reset during a stall
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    step("prestall");
    async_reset("midreset");
    chk("midreset.pc_c", mf.imem_addr, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
            $urandom(), $urandom());
      step("rand");
      if ($urandom_range(0, 49) == 0) begin
        async_reset("randreset");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
